prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Processor-side responder to the bench Start/Done program handshake.
- Converts bench Start requests into fetch-hold and absolute-jump commands for the PC.
- Tracks which program (0..NUM_PROGS-1) is running and counts its execution cycles.
- Sits between the test bench, instruction decode (Halt) and the program counter.

Parameters:
- PC_W, 10: program counter / target width.
- NUM_PROGS, 3: programs in the series; ProgIdx wraps after NUM_PROGS-1.
- BASE0, 0: start address, program 0.
- BASE1, 256: start address, program 1.
- BASE2, 512: start address, program 2.
- CYC_W, 16: cycle counter width.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  bench request; high = hold; falling level = begin program.
- Halt  in  1  decode saw the program-terminating instruction this cycle.
- FetchHold  out  1  to PC: hold current value.
- LoadEn  out  1  to PC: absolute jump to LoadTarget.
- LoadTarget  out  PC_W  jump target = base of current ProgIdx.
- Done  out  1  to bench: current program finished.
- Busy  out  1  high in LAUNCH or RUN.
- ProgIdx  out  2  index of current/next program.
- CycleCount  out  CYC_W  RUN cycles of the last/current program.

Behaviour:
- Moore FSM; all outputs decode from registered state/counters. No combinational path from inputs to outputs.
- Reset low, asynchronously:
  - state=IDLE, ProgIdx=0, CycleCount=0.
  - FetchHold=1, LoadEn=0, Done=0, Busy=0, LoadTarget=BASE0.
- Reset takes effect immediately at any time, including mid-RUN.
- States:
  - IDLE: FetchHold=1. Start=1 -> ARMED.
  - ARMED: FetchHold=1, Done=0. Stays while Start=1. Start=0 -> LAUNCH.
  - LAUNCH: exactly one cycle. LoadEn=1, FetchHold=0, Busy=1, LoadTarget=BASE[ProgIdx]. CycleCount<=0 at the exiting edge. -> RUN.
  - RUN: FetchHold=0, LoadEn=0, Busy=1.
    - CycleCount +1 on every edge in RUN, including the exiting edge.
    - CycleCount saturates at all-ones.
    - Halt=1 -> DONE; ProgIdx<=ProgIdx+1, wrapping NUM_PROGS-1 -> 0.
  - DONE: Done=1, FetchHold=1, CycleCount frozen. Start=1 -> ARMED (Done drops the next cycle).
- Simultaneous events and boundary cases:
  - Start=1 in RUN: abort -> ARMED. ProgIdx unchanged; CycleCount frozen at its current value.
  - Start and Halt both 1 in RUN: Start wins (abort, no increment).
  - Halt outside RUN: ignored.
- Latency:
  - Start sampled 0 at edge k (in ARMED) -> LoadEn high during cycle k..k+1.
  - PC loads the target at edge k+1; the first instruction executes in cycle k+1..k+2.
- LoadTarget is a mux of BASE0..BASE2 on ProgIdx. Indices >= NUM_PROGS never occur.

Decomposition:
- Package prog_seq_pkg:
  - state enum {IDLE, ARMED, LAUNCH, RUN, DONE}, 3-bit encoding.
  - PC_W/CYC_W default constants.
  - typedef of the base-address array.
- Sub-module sat_counter (width-parameterised; clear, enable, saturate) for CycleCount.
- Everything else lives in prog_sequencer.

Test Plan:
1. Reset driven low mid-RUN with CycleCount=7 -> same-cycle IDLE, FetchHold=1, Done=0, ProgIdx=0, CycleCount=0.
2. Start high 3 cycles then low -> exactly one LoadEn cycle with LoadTarget=0. Halt in 20th RUN cycle -> Done=1, CycleCount=20, ProgIdx=1.
3. Three full Start/Halt sequences -> LoadTarget 0, 256, 512; fourth launch -> 0, ProgIdx wraps to 0.
4. Start raised in 5th RUN cycle of program 1 -> ARMED, ProgIdx stays 1, CycleCount=4 frozen, Done=0. Relaunch targets 256.
5. Halt and Start high on the same RUN edge -> ARMED, ProgIdx unchanged, Done never asserted.
6. CYC_W=4 override, 30 RUN cycles then Halt -> CycleCount=15; Halt pulsed in IDLE/ARMED -> no state change.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types and default widths for the program sequencer
package prog_seq_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CYC_W_DEF = 16;
    localparam int MAX_PROGS = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // Start addresses indexed by ProgIdx; the spare slot is never selected
    typedef logic [31:0] base_arr_t [MAX_PROGS];

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - width-parameterised up-counter with clear and saturation
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // clear takes priority; once all-ones the count holds instead of wrapping
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - Start/Done program handshake responder driving PC hold and jump
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int NUM_PROGS = 3,
    parameter int BASE0     = 0,
    parameter int BASE1     = 256,
    parameter int BASE2     = 512,
    parameter int CYC_W     = CYC_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             FetchHold,
    output logic             LoadEn,
    output logic [PC_W-1:0]  LoadTarget,
    output logic             Done,
    output logic             Busy,
    output logic [1:0]       ProgIdx,
    output logic [CYC_W-1:0] CycleCount
);

    localparam base_arr_t BASES = '{BASE0, BASE1, BASE2, BASE0};

    function automatic logic [PC_W-1:0] base_of(input logic [1:0] idx);
        return PC_W'(BASES[idx]);
    endfunction

    seq_state_t state;
    seq_state_t state_nxt;
    logic [1:0] idx_nxt;
    logic       cnt_clear;
    logic       cnt_enable;

    assign idx_nxt = (ProgIdx == 2'(NUM_PROGS - 1)) ? 2'd0 : ProgIdx + 2'd1;

    // Start in RUN aborts back to ARMED and beats a simultaneous Halt
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start)  state_nxt = ARMED;
            ARMED:   if (!Start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = RUN;
            RUN: begin
                if (Start)     state_nxt = ARMED;
                else if (Halt) state_nxt = DONE;
            end
            DONE:    if (Start)  state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with outputs registered from the next state so they line up with it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ProgIdx    <= 2'd0;
            LoadTarget <= PC_W'(BASE0);
            FetchHold  <= 1'b1;
            LoadEn     <= 1'b0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            FetchHold <= (state_nxt == IDLE) || (state_nxt == ARMED) || (state_nxt == DONE);
            LoadEn    <= (state_nxt == LAUNCH);
            Busy      <= (state_nxt == LAUNCH) || (state_nxt == RUN);
            Done      <= (state_nxt == DONE);
            if ((state == RUN) && (state_nxt == DONE)) begin
                ProgIdx    <= idx_nxt;
                LoadTarget <= base_of(idx_nxt);
            end
        end
    end

    // Count restarts when leaving LAUNCH; an abort edge does not count
    assign cnt_clear  = (state == LAUNCH);
    assign cnt_enable = (state == RUN) && !Start;

    sat_counter #(
        .W(CYC_W)
    ) u_cycle_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (CycleCount)
    );

endmodule
